// File: rtl/encoder_8x3_seq.sv
// ============================================================================
// Module   : encoder_8x3_seq
// Brief    : Sequential 8-to-3 encoder; drains set request bits lowest first
//            over a valid/ready port and flags one-hot captures.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_8x3_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] D,
  input  logic       out_ready,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
  output logic       none,
  output logic       onehot
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pending;
  logic [7:0] w_pending_nxt;
  logic [7:0] w_remain;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic       r_done;
  logic       w_done_nxt;
  logic       r_none;
  logic       w_none_nxt;
  logic       r_onehot;
  logic       w_onehot_nxt;

  function automatic logic [2:0] f_lowest(input logic [7:0] v);
    f_lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) f_lowest = 3'(i);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= 8'h00;
      r_idx     <= 3'd0;
      r_done    <= 1'b0;
      r_none    <= 1'b0;
      r_onehot  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_idx     <= w_idx_nxt;
      r_done    <= w_done_nxt;
      r_none    <= w_none_nxt;
      r_onehot  <= w_onehot_nxt;
    end
  end

  // Clearing the lowest set bit always removes the index currently shown.
  assign w_remain = r_pending & (r_pending - 8'd1);

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_idx_nxt     = r_idx;
    w_done_nxt    = 1'b0;
    w_none_nxt    = 1'b0;
    w_onehot_nxt  = r_onehot;
    case (r_state)
      IDLE: begin
        if (load) begin
          if (D != 8'h00) begin
            w_pending_nxt = D;
            w_idx_nxt     = f_lowest(D);
            w_onehot_nxt  = ((D & (D - 8'd1)) == 8'h00);
            w_state_nxt   = EMIT;
          end else begin
            w_none_nxt   = 1'b1;
            w_onehot_nxt = 1'b0;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          w_pending_nxt = w_remain;
          if (w_remain != 8'h00) begin
            w_idx_nxt = f_lowest(w_remain);
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign x         = r_idx[2];
  assign y         = r_idx[1];
  assign z         = r_idx[0];
  assign out_valid = (r_state == EMIT);
  assign busy      = (r_state == EMIT);
  assign done      = r_done;
  assign none      = r_none;
  assign onehot    = r_onehot;

endmodule

`default_nettype wire
